legv8_if_id_queue: RTL and testbench

- Instruction fetch queue between the LEGv8 IF stage (PC register plus instruction memory) and the ID stage.
- Buffers {PC, instruction} pairs so IF keeps fetching while ID stalls.
- Drops all buffered, wrong-path instructions in one cycle when a branch is taken (PCSrc=1).
- Valid/ready handshake on both sides.

---
 rtl/legv8_pkg.sv | 16 +
 rtl/legv8_if_id_queue_if.sv | 39 +++
 rtl/legv8_ifq_ram.sv | 25 ++
 rtl/legv8_if_id_queue.sv | 83 ++++++++
 tb/tb_legv8_if_id_queue.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types: instruction/address widths and the IF->ID entry record.
package legv8_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  // Bubble word the ID stage injects; the queue itself outputs zeros when empty.
  localparam logic [INSTR_W-1:0] LEGV8_NOP = 32'hD503201F;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/legv8_if_id_queue_if.sv
// IF->ID queue bus: fetch-side push handshake, decode-side pop handshake, flush and occupancy.
// With LEGV8_IFQ_PERF_EN defined the bus also carries the flush drop counter.
interface legv8_if_id_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              flush;
  logic              in_valid;
  logic [63:0]       in_pc;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              out_valid;
  logic [63:0]       out_pc;
  logic [31:0]       out_instr;
  logic              out_ready;
  logic [PTR_W:0]    count;
`ifdef LEGV8_IFQ_PERF_EN
  logic [31:0]       flush_drop_cnt;

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count, flush_drop_cnt
  );
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count, flush_drop_cnt
  );
`else
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
`endif
endinterface

// File: rtl/legv8_ifq_ram.sv
// DEPTH-entry storage for the IF->ID queue: one synchronous write port, one combinational read port.
module legv8_ifq_ram
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  if_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output if_entry_t        rdata
);

  if_entry_t mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the count in the top, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/legv8_if_id_queue.sv
// IF->ID instruction queue: buffers {pc, instr} while ID stalls, drops everything on a taken branch.
// Optional LEGV8_IFQ_PERF_EN adds a saturating count of entries discarded by flushes.
module legv8_if_id_queue
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  legv8_if_id_queue_if.slave   q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("legv8_if_id_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             in_ready, out_valid, push, pop;
  if_entry_t        wdata, rdata;

  // in_ready deliberately ignores out_ready: a full queue never accepts, even while popping.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = q.in_valid & in_ready & ~q.flush;
  assign pop       = out_valid & q.out_ready & ~q.flush;

  assign wdata = '{pc: q.in_pc, instr: q.in_instr};

  legv8_ifq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = out_valid ? rdata.pc    : '0;
  assign q.out_instr = out_valid ? rdata.instr : '0;
  assign q.count     = count_q;

`ifdef LEGV8_IFQ_PERF_EN
  logic [31:0] drop_cnt;
  logic [32:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + 33'(count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          drop_cnt <= '0;
    else if (q.flush) drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  assign q.flush_drop_cnt = drop_cnt;
`endif

endmodule

// File: tb/tb_legv8_if_id_queue.sv
// Self-checking bench for legv8_if_id_queue: directed plan scenarios plus a random run against a queue model.
// Define LEGV8_IFQ_PERF_EN to also exercise the flush drop counter.
module tb_legv8_if_id_queue;
  import legv8_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  legv8_if_id_queue_if #(.DEPTH(DEPTH)) bus ();

  legv8_if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents in acceptance order, plus the drop tally.
  if_entry_t   mq[$];
  logic [31:0] m_drop;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    return 32'h8B00_0000 | pc[31:0];
  endfunction

  // Drive one cycle of inputs, take the edge, update the model, then sit 1ns past the edge.
  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    bit do_push, do_pop;
    longint unsigned sum;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    if (fl) begin
      sum    = longint'(m_drop) + longint'(mq.size());
      m_drop = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
      mq.delete();
    end else begin
      do_push = v && (mq.size() != DEPTH);
      do_pop  = rdy && (mq.size() != 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: pc, instr: ins});
    end
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_drop = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== CW'(0) || bus.in_ready !== 1'b1 ||
        bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin
      n_err++;
      $display("FAIL reset: out_valid=%b count=%0d in_ready=%b out_pc=%h out_instr=%h, want 0/0/1/0/0",
               bus.out_valid, bus.count, bus.in_ready, bus.out_pc, bus.out_instr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 64'h0, 32'h8B020020, 1'b0, 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h8B020020 ||
        bus.count !== CW'(1)) begin
      n_err++;
      $display("FAIL single_push: valid=%b pc=%h instr=%h count=%0d, want 1/0/8b020020/1",
               bus.out_valid, bus.out_pc, bus.out_instr, bus.count);
    end
    drain();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b0, 1'b0);
    n_vec++;
    if (bus.count !== CW'(DEPTH) || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill: count=%0d in_ready=%b, want %0d/0", bus.count, bus.in_ready, DEPTH);
    end
    drive(1'b1, 64'h10, mk_instr(64'h10), 1'b0, 1'b0);
    n_vec++;
    if (bus.count !== CW'(DEPTH) || bus.out_pc !== 64'h0) begin
      n_err++;
      $display("FAIL full_refuse: count=%0d head=%h, want %0d/0", bus.count, bus.out_pc, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(i * 4) || bus.out_instr !== mk_instr(64'(i * 4))) begin
        n_err++;
        $display("FAIL drain_order[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, i * 4, mk_instr(64'(i * 4)));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== CW'(0) || bus.out_pc !== 64'h0) begin
      n_err++;
      $display("FAIL drain_empty: valid=%b count=%0d pc=%h, want 0/0/0", bus.out_valid, bus.count, bus.out_pc);
    end
    // Popping an empty queue must leave it empty.
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_vec++;
    if (bus.count !== CW'(0) || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_pop: count=%0d valid=%b, want 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b1, 1'b0);
      n_vec++;
      if (bus.count !== CW'(1) || bus.out_pc !== 64'(i * 4) || bus.out_instr !== mk_instr(64'(i * 4))) begin
        n_err++;
        $display("FAIL stream[%0d]: count=%0d pc=%h instr=%h, want 1/%h/%h",
                 i, bus.count, bus.out_pc, bus.out_instr, i * 4, mk_instr(64'(i * 4)));
      end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h20 + 64'(i * 4), mk_instr(64'h20 + 64'(i * 4)), 1'b0, 1'b0);
    drive(1'b1, 64'h40, mk_instr(64'h40), 1'b1, 1'b1);
    n_vec++;
    if (bus.count !== CW'(0) || bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush: count=%0d valid=%b pc=%h in_ready=%b, want 0/0/0/1",
               bus.count, bus.out_valid, bus.out_pc, bus.in_ready);
    end
    drive(1'b1, 64'h100, mk_instr(64'h100), 1'b0, 1'b0);
    n_vec++;
    if (bus.out_pc !== 64'h100 || bus.count !== CW'(1)) begin
      n_err++;
      $display("FAIL branch_target: pc=%h count=%0d, want 100/1", bus.out_pc, bus.count);
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h200, mk_instr(64'h200), 1'b0, 1'b0);
    drive(1'b1, 64'h204, mk_instr(64'h204), 1'b0, 1'b0);
    n_vec++;
    if (bus.count !== CW'(2)) begin
      n_err++;
      $display("FAIL pre_async_reset: count=%0d, want 2", bus.count);
    end
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== CW'(0) || bus.out_pc !== 64'h0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d pc=%h, want 0/0/0", bus.out_valid, bus.count, bus.out_pc);
    end
    mq.delete();
    m_drop = '0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        v, rdy, fl;
    logic [63:0] pc;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    for (int i = 0; i < 400; i++) begin
      exp_pc    = (mq.size() != 0) ? mq[0].pc    : 64'h0;
      exp_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
      n_vec++;
      if (bus.out_valid !== (mq.size() != 0) || bus.in_ready !== (mq.size() != DEPTH) ||
          bus.count !== CW'(mq.size()) || bus.out_pc !== exp_pc || bus.out_instr !== exp_instr) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b rdy=%b count=%0d pc=%h instr=%h, want %b/%b/%0d/%h/%h",
                 i, bus.out_valid, bus.in_ready, bus.count, bus.out_pc, bus.out_instr,
                 mq.size() != 0, mq.size() != DEPTH, mq.size(), exp_pc, exp_instr);
      end
`ifdef LEGV8_IFQ_PERF_EN
      n_vec++;
      if (bus.flush_drop_cnt !== m_drop) begin
        n_err++;
        $display("FAIL random_drop[%0d]: got %0d want %0d", i, bus.flush_drop_cnt, m_drop);
      end
`endif
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      pc  = {$urandom, $urandom};
      drive(v, pc, $urandom, rdy, fl);
    end
    drain();
  endtask

`ifdef LEGV8_IFQ_PERF_EN
  task automatic test_perf();
    sync_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_vec++;
    if (bus.flush_drop_cnt !== 32'd5) begin
      n_err++;
      $display("FAIL drop_sum: got %0d want 5", bus.flush_drop_cnt);
    end
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'(i * 4), mk_instr(64'(i * 4)), 1'b0, 1'b0);
    force dut.drop_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.drop_cnt;
    m_drop = 32'hFFFF_FFFE;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_vec++;
    if (bus.flush_drop_cnt !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL drop_saturate: got %h want ffffffff", bus.flush_drop_cnt);
    end
  endtask
`endif

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    mq.delete();
    m_drop = '0;

    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
`ifdef LEGV8_IFQ_PERF_EN
    test_perf();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
